// File: rtl/line_printer_pkg.sv
// Shared types and constants for the line printer: formatter states, FIFO entry
// layout, and the byte/next-state rules for the formatter.
package line_printer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_L,
    SEND_COLON,
    SEND_R,
    SEND_SEP,
    SEND_CR,
    SEND_LF
  } fmt_state_t;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef struct packed {
    logic       last;
    logic [7:0] lhs;
    logic [7:0] rhs;
  } pair_t;

  function automatic logic [7:0] fmt_byte(fmt_state_t s, pair_t e);
    case (s)
      SEND_L:     return e.lhs;
      SEND_COLON: return ASCII_COLON;
      SEND_R:     return e.rhs;
      SEND_SEP:   return ASCII_SPACE;
      SEND_CR:    return ASCII_CR;
      SEND_LF:    return ASCII_LF;
      default:    return 8'h00;
    endcase
  endfunction

  // The rhs byte ends a line with CR/LF, otherwise a single space separator.
  function automatic fmt_state_t next_state(fmt_state_t s, logic last);
    case (s)
      SEND_L:     return SEND_COLON;
      SEND_COLON: return SEND_R;
      SEND_R:     return last ? SEND_CR : SEND_SEP;
      SEND_CR:    return SEND_LF;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/line_printer_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each bit
// exactly CLKS_PER_BIT cycles. A byte is accepted only while not busy.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;

  // shreg carries the data bits with the stop bit queued behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        tx      <= 1'b0;
        shreg   <= {1'b1, tx_byte};
        clk_cnt <= '0;
        bit_idx <= '0;
      end
    end else if (clk_cnt == LAST_CLK) begin
      clk_cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_printer.sv
// Buffers {lhs, rhs, last} pairs in a small FIFO and prints each as "l:r"
// followed by a space or CR/LF over a UART.
module line_printer
  import line_printer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pair_valid,
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  input  logic       pair_last,
  output logic       pair_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  pair_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  fmt_state_t state;
  pair_t      entry;
  logic       start_q;
  logic [7:0] byte_q;
  logic       uart_busy, uart_idle;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign pair_ready = !full;
  assign push       = pair_valid && !full;
  assign pop        = (state == IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: pair_last, lhs: lhs, rhs: rhs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pair_valid && full) overflow <= 1'b1;
    end
  end

  // A byte handed over last cycle has not reached the UART's busy flag yet.
  assign uart_idle = !uart_busy && !start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      entry   <= '0;
      start_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            entry <= mem[rd_ptr];
            state <= SEND_L;
          end
        end
        default: begin
          if (uart_idle) begin
            start_q <= 1'b1;
            byte_q  <= fmt_byte(state, entry);
            state   <= next_state(state, entry.last);
          end
        end
      endcase
    end
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .tx_byte (byte_q),
    .start   (start_q),
    .busy    (uart_busy),
    .tx      (tx)
  );

  assign busy = !empty || (state != IDLE) || uart_busy || start_q;

endmodule

// File: tb/tb_line_printer.sv
// Bench for line_printer: table vectors, hand-built corner sequences and a
// randomized phase checked against a byte-stream model of the printed lines.
module tb_line_printer;

  localparam int C = 16;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst, pair_valid, pair_last;
  logic [7:0] lhs, rhs;
  logic       pair_ready, tx, busy, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic       m_act = 1'b0;
  int         m_cnt = 0;
  int         m_idx;
  logic [7:0] m_byte;

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  r;
    logic        last;
    logic [39:0] e;
    int          n;
  } vec_t;
  vec_t tbl[4];

  line_printer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pair_valid (pair_valid),
    .lhs        (lhs),
    .rhs        (rhs),
    .pair_last  (pair_last),
    .pair_ready (pair_ready),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART receiver: samples mid-bit, aborts on reset.
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act = 1'b1;
        m_cnt = 1;
        last_start = cyc;
      end
    end else begin
      m_cnt++;
      if (m_cnt % C == C / 2) begin
        m_idx = m_cnt / C;
        if (m_idx == 0) chk("start_bit", {31'd0, tx}, 32'd0);
        else if (m_idx <= 8) m_byte[m_idx-1] = tx;
        else begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(m_byte);
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic fmt(input logic [7:0] l, input logic [7:0] r, input logic last);
    exp_q.push_back(l);
    exp_q.push_back(8'h3A);
    exp_q.push_back(r);
    if (last) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  task automatic offer(input logic [7:0] l, input logic [7:0] r, input logic last,
                       output logic acc);
    pair_valid = 1'b1;
    lhs        = l;
    rhs        = r;
    pair_last  = last;
    acc        = pair_ready;
    @(negedge clk);
    pair_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, {31'd0, busy}, 32'd0);
    chk({name, "_busy_fall"}, cyc - last_start, FRAME);
  endtask

  task automatic cmp_q(input string name);
    int n;
    chk({name, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic       acc;
    logic       dropped;
    logic [9:0] frame;
    int         k, n, bad;
    logic [7:0] rl, rr;
    logic       rlast;

    tbl[0] = '{8'h61, 8'h62, 1'b1, 40'h61_3A_62_0D_0A, 5};
    tbl[1] = '{8'h55, 8'hAA, 1'b0, 40'h55_3A_AA_20_00, 4};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 40'h00_3A_FF_0D_0A, 5};
    tbl[3] = '{8'h7E, 8'h01, 1'b0, 40'h7E_3A_01_20_00, 4};

    rst = 1'b1; pair_valid = 1'b0; lhs = '0; rhs = '0; pair_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_ready", {31'd0, pair_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      offer(tbl[i].l, tbl[i].r, tbl[i].last, acc);
      chk($sformatf("tbl%0d_accept", i), {31'd0, acc}, 32'd1);
      wait_idle(6 * FRAME, $sformatf("tbl%0d", i));
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].e[39-8*j -: 8]);
      cmp_q($sformatf("tbl%0d", i));
    end

    // Latency from push edge and exact bit timing of a 0x55 frame.
    offer(8'h55, 8'h41, 1'b1, acc);
    k = cyc;
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - k, 32'd3);
    frame = {1'b1, 8'h55, 1'b0};
    bad = 0;
    for (int j = 0; j < FRAME; j++) begin
      if (tx !== frame[j / C]) bad++;
      @(negedge clk);
    end
    chk("wave_0x55", bad, 32'd0);
    wait_idle(6 * FRAME, "wave");
    fmt(8'h55, 8'h41, 1'b1);
    cmp_q("wave");

    // Three pairs on one line.
    offer("a", "b", 1'b0, acc); chk("line_acc0", {31'd0, acc}, 32'd1);
    offer("c", "d", 1'b0, acc); chk("line_acc1", {31'd0, acc}, 32'd1);
    offer("e", "f", 1'b1, acc); chk("line_acc2", {31'd0, acc}, 32'd1);
    wait_idle(15 * FRAME, "line");
    fmt("a", "b", 1'b0); fmt("c", "d", 1'b0); fmt("e", "f", 1'b1);
    chk("line_len", exp_q.size(), 32'd13);
    cmp_q("line");

    // Overflow: formatter busy with p0, six consecutive offers into a 4-deep FIFO.
    offer(8'h30, 8'h31, 1'b0, acc);
    fmt(8'h30, 8'h31, 1'b0);
    repeat (20) @(negedge clk);
    for (int j = 1; j <= 6; j++) begin
      offer(8'h40 + 8'(j), 8'h50 + 8'(j), (j == 4), acc);
      chk($sformatf("ovf_ready%0d", j), {31'd0, acc}, (j <= 4) ? 32'd1 : 32'd0);
      if (j <= 4) fmt(8'h40 + 8'(j), 8'h50 + 8'(j), (j == 4));
    end
    chk("ovf_ready_full", {31'd0, pair_ready}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    wait_idle(30 * FRAME, "ovf");
    chk("ovf_sticky_after", {31'd0, overflow}, 32'd1);
    cmp_q("ovf");

    // Reset in the middle of a data bit of the second byte.
    offer(8'h71, 8'h72, 1'b1, acc);
    n = 0;
    while (rx_q.size() < 1 && n < 2 * FRAME) begin @(negedge clk); n++; end
    n = 0;
    while (tx !== 1'b0 && n < 2 * FRAME) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_ready", {31'd0, pair_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_partial", rx_q.size(), 32'd1);
    rx_q.delete();
    @(negedge clk);
    offer(8'h68, 8'h69, 1'b1, acc);
    wait_idle(6 * FRAME, "post_rst");
    fmt(8'h68, 8'h69, 1'b1);
    cmp_q("post_rst");

    // Randomized offers with random spacing; drops follow the ready handshake.
    dropped = 1'b0;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      rl    = 8'($urandom_range(32, 126));
      rr    = 8'($urandom_range(32, 126));
      rlast = ($urandom_range(0, 3) == 0);
      offer(rl, rr, rlast, acc);
      if (acc) fmt(rl, rr, rlast);
      else dropped = 1'b1;
    end
    wait_idle(25 * 5 * (FRAME + 4), "rand");
    chk("rand_overflow", {31'd0, overflow}, {31'd0, dropped});
    cmp_q("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_printer.md
LINE_PRINTER -- requirements
Module: line_printer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per UART bit (minimum 2).
REQ-002 Parameter FIFO_DEPTH, default 4, number of pair entries buffered (power of two, minimum 2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pair_valid  input  1  lhs/rhs/pair_last hold a character pair to print.
REQ-006 lhs  input  8  ASCII input character.
REQ-007 rhs  input  8  ASCII transformed character.
REQ-008 pair_last  input  1  this pair is the last pair of its line.
REQ-009 pair_ready  output  1  combinational; high when FIFO not full.
REQ-010 tx  output  1  UART 8N1 serial output, idle high.
REQ-011 busy  output  1  high when FIFO non-empty, or formatter not IDLE, or UART shifting.
REQ-012 overflow  output  1  sticky; set when a pair is offered while full.

Function
REQ-013 Push occurs on an edge where pair_valid and pair_ready are both high; entry {pair_last, lhs, rhs} (17 bits) is written at the tail.
REQ-014 pair_ready is derived from full only; a pop in the same cycle does not make a full FIFO accept.
REQ-015 pair_valid high while full: data dropped, overflow set on that edge, FIFO unchanged.
REQ-016 Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
REQ-017 Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-018 Formatter FSM states: IDLE, SEND_L, SEND_COLON, SEND_R, SEND_SEP, SEND_CR, SEND_LF.
REQ-019 IDLE with FIFO non-empty: pop head into an entry register, go to SEND_L.
REQ-020 Each SEND_x state issues one byte to the UART when it is idle, then advances on that edge.
REQ-021 Bytes per entry: lhs, 0x3A ':', rhs, then 0x20 ' ' if pair_last=0 (SEND_SEP), else 0x0D then 0x0A (SEND_CR, SEND_LF).
REQ-022 After the final byte of an entry the FSM returns to IDLE; back-to-back entries add no gap beyond one IDLE cycle.
REQ-023 UART frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-024 UART accepts a new byte in the cycle after the stop bit completes; no shortened stop bit.
REQ-025 Latency: push into empty idle block at edge k -> tx low from edge k+3 onward.
REQ-026 Byte order on tx is strictly FIFO order; no entry is skipped or repeated.

Reset
REQ-027 rst high at an edge: FIFO empty, pointers 0, FSM IDLE, UART idle, tx=1, busy=0, overflow=0, pair_ready=1.
REQ-028 Reset mid-frame aborts the byte; tx is 1 from the next edge; partial line is discarded.
REQ-029 Reset has priority over push, pop and transmit in the same cycle.

Structure
REQ-030 Package line_printer_pkg holds the FSM state enum and constants ASCII_COLON, ASCII_SPACE, ASCII_CR, ASCII_LF.
REQ-031 One sub-module, uart_tx (byte, start, busy, tx; parameter CLKS_PER_BIT); FIFO and formatter are inline.

Verification
REQ-032 Reset, single pair lhs=0x61 rhs=0x62 pair_last=1 -> tx bytes 0x61,0x3A,0x62,0x0D,0x0A; busy falls after LF stop bit.
REQ-033 Three pairs (a/b, c/d, e/f last) -> "a:b c:d e:f\r\n" exactly, 13 bytes.
REQ-034 CLKS_PER_BIT=16, byte 0x55 -> start bit 16 cycles low, bits 1,0,1,0,1,0,1,0, stop 16 cycles high.
REQ-035 Hold pair_valid high for 6 pairs with FIFO_DEPTH=4 during transmission -> pair_ready low when full, overflow set, dropped pairs never appear on tx.
REQ-036 Assert rst mid data bit of second byte -> tx=1 next cycle, busy=0, overflow=0; subsequent pair prints correctly.
REQ-037 Push into empty block at edge k -> tx first low at edge k+3.
